led_green_scheduler: RTL and testbench
======================================

# led_green_scheduler

Shares the green-LED PIO slave (9-bit output register at offset 0, zero-wait-state Avalon writes) among several on-chip requesters, such as video-pipeline status, error flags and heartbeat. A round-robin arbiter accepts one update at a time and issues a single Avalon write to the PIO. It then holds off further updates for a minimum dwell time so that the LEDs never flicker faster than the eye can follow. Writes that would not change the LEDs are suppressed against a shadow copy. The block sits between the status sources and the PIO's s1 slave, in place of a direct master connection.

## Interface
- NUM_REQ, 3: number of requesters, 2..8.
- LED_WIDTH, 9: LED vector width; must match the PIO output width.
- DWELL_CYCLES, 1024: minimum number of cycles spent in DWELL after each real write, ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester update request; held until accepted.
- req_data  in  NUM_REQ*LED_WIDTH  requested LED value; requester i owns slice [i*LED_WIDTH +: LED_WIDTH], stable while valid.
- req_ready  out  NUM_REQ  one-hot accept; a transfer occurs on valid & ready.
- pio_address  out  2  PIO register address; always 0.
- pio_chipselect  out  1  PIO chipselect.
- pio_write_n  out  1  PIO active-low write strobe.
- pio_writedata  out  32  {zeros, LED value}.
- shadow  out  LED_WIDTH  last value written to the PIO.
- busy  out  1  high in WRITE or DWELL.

## Operation
- FSM states are IDLE, WRITE and DWELL.
- IDLE:
  - If any req_valid is high, the arbiter picks index g, searching round-robin from last_grant+1 upward with wrap.
  - req_ready[g] is asserted combinationally in the same cycle (Mealy output).
  - The cycle latches cap_data ← req_data[g] and last_grant ← g.
  - If req_data[g] == shadow, the write is skipped and the FSM stays in IDLE.
  - Otherwise the FSM goes to WRITE.
- WRITE (exactly 1 cycle):
  - Drives pio_chipselect=1, pio_write_n=0, pio_address=0, pio_writedata={(32-LED_WIDTH)'b0, cap_data}.
  - shadow ← cap_data.
  - The dwell counter loads DWELL_CYCLES-1, and the FSM goes to DWELL.
- DWELL:
  - The counter decrements each cycle.
  - When the counter is 0, the FSM goes to IDLE.
  - req_ready stays low throughout.
- Outside WRITE, the PIO outputs are held at chipselect=0, write_n=1, writedata=0 and address=0.
- The dwell counter width is $clog2(DWELL_CYCLES+1) and it never underflows.
- Reset values:
  - state=IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first), shadow=0 (matches the PIO reset value), cap_data=0, counter=0.
  - req_ready=0, busy=0.
  - pio_chipselect=0, pio_write_n=1, pio_writedata=0, pio_address=0.
- A request that drops before it is accepted is simply lost; no state is retained for it.
- Simultaneous requests are served in round-robin order. No requester is starved: each waits at most NUM_REQ-1 grants.

## Timing
- Accept in IDLE at cycle n with a changed value:
  - The PIO write strobe is active in cycle n+1.
  - shadow updates at the end of cycle n+1.
  - DWELL occupies cycles n+2 .. n+1+DWELL_CYCLES.
  - The earliest next accept is cycle n+2+DWELL_CYCLES.
- Accept with an unchanged value: no write occurs, and the next accept can happen in cycle n+1.
- req_ready is asserted only in IDLE, and only for the arbiter's pick.
- Reset asserted mid-WRITE drops pio_chipselect immediately (asynchronously). A partially strobed cycle is acceptable because the PIO shares the same reset.
- Reset mid-DWELL discards the remaining dwell time.

## Structure
- Package led_sched_pkg:
  - state enum (IDLE/WRITE/DWELL).
  - PIO_ADDR_DATA = 2'd0.
  - AVALON_DATA_W = 32.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N] and last[$clog2(N)].
  - Outputs: grant one-hot, grant_idx, any.
  - Purely combinational rotate-and-priority-encode.
  - Instantiated once inside led_green_scheduler, which holds the FSM, counter, shadow and capture registers.

## Test plan
- Reset then single request, with DWELL_CYCLES=4:
  - req_valid=001, data0=9'h0A5 → req_ready=001 at n.
  - One write at n+1 with writedata=32'h000000A5; shadow=9'h0A5.
  - busy is high from n+1 through n+5.
- Round-robin with all three requesters held valid, with data 9'h001, 9'h002, 9'h004:
  - Grants follow the order 0,1,2,0.
  - Writes of 1, 2, 4, 1 are each separated by exactly 1+DWELL_CYCLES cycles.
- Redundant suppression:
  - Write 9'h1FF, then request 9'h1FF again → ready pulses but no chipselect occurs.
  - A different request on the next cycle is accepted immediately.
- Dwell enforcement:
  - A request raised during DWELL → ready stays low until the counter reaches 0.
  - It is then accepted in the first IDLE cycle.
- Reset mid-operation:
  - Assert reset during the WRITE cycle → chipselect=0 and write_n=1 within the same cycle.
  - shadow=0, state=IDLE.
  - After release, requester 0 has priority.

Source files
------------

// File: rtl/led_sched_pkg.sv
// Shared types and constants for the green-LED PIO write scheduler.
package led_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DWELL = 2'd2
  } state_e;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam int         AVALON_DATA_W = 32;

endpackage

// File: rtl/led_green_scheduler_rr_arbiter.sv
// Combinational round-robin pick: search upward from last+1 with wrap.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [LW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int off = 1; off <= N; off++) begin
      if (!any && req[(int'(last) + off) % N]) begin
        any                            = 1'b1;
        grant[(int'(last) + off) % N]  = 1'b1;
        grant_idx                      = LW'((int'(last) + off) % N);
      end
    end
  end

endmodule

// File: rtl/led_green_scheduler.sv
// Arbitrates LED updates from several requesters into single PIO writes,
// suppressing redundant values and enforcing a minimum dwell between writes.
//
// state | meaning
// IDLE  | accept one request from the round-robin pick
// WRITE | one-cycle Avalon write strobe to the PIO
// DWELL | hold-off so the LEDs cannot flicker
module led_green_scheduler
  import led_sched_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int LED_WIDTH    = 9,
  parameter int DWELL_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*LED_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [1:0]                     pio_address,
  output logic                           pio_chipselect,
  output logic                           pio_write_n,
  output logic [AVALON_DATA_W-1:0]       pio_writedata,
  output logic [LED_WIDTH-1:0]           shadow,
  output logic                           busy
);

  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(DWELL_CYCLES + 1);

  state_e                   state_q, state_d;
  logic [LW-1:0]            last_q, last_d;
  logic [LED_WIDTH-1:0]     cap_q, cap_d;
  logic [LED_WIDTH-1:0]     shadow_q, shadow_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     cs_q, cs_d;
  logic                     wrn_q, wrn_d;
  logic [AVALON_DATA_W-1:0] wdata_q, wdata_d;

  logic [NUM_REQ-1:0]       grant;
  logic [LW-1:0]            grant_idx;
  logic                     any;
  logic [LED_WIDTH-1:0]     sel_data;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign sel_data = req_data[int'(grant_idx)*LED_WIDTH +: LED_WIDTH];

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cap_d     = cap_q;
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          req_ready = grant;
          last_d    = grant_idx;
          cap_d     = sel_data;
          if (sel_data != shadow_q) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        shadow_d = cap_q;
        cnt_d    = CW'(DWELL_CYCLES - 1);
        state_d  = ST_DWELL;
      end
      ST_DWELL: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    // PIO strobes are registered off the next state so they align with WRITE.
    cs_d    = (state_d == ST_WRITE);
    wrn_d   = !cs_d;
    wdata_d = cs_d ? {{(AVALON_DATA_W-LED_WIDTH){1'b0}}, cap_d} : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      last_q   <= LW'(NUM_REQ - 1);
      cap_q    <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      cs_q     <= 1'b0;
      wrn_q    <= 1'b1;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cap_q    <= cap_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      cs_q     <= cs_d;
      wrn_q    <= wrn_d;
      wdata_q  <= wdata_d;
    end
  end

  assign pio_address    = PIO_ADDR_DATA;
  assign pio_chipselect = cs_q;
  assign pio_write_n    = wrn_q;
  assign pio_writedata  = wdata_q;
  assign shadow         = shadow_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_green_scheduler.sv
// Directed checks of arbitration, write timing, suppression, dwell and reset.
module tb_led_green_scheduler;

  localparam int NR = 3;
  localparam int LW = 9;
  localparam int D  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*LW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [1:0]       pio_address;
  logic             pio_chipselect;
  logic             pio_write_n;
  logic [31:0]      pio_writedata;
  logic [LW-1:0]    shadow;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  led_green_scheduler #(.NUM_REQ(NR), .LED_WIDTH(LW), .DWELL_CYCLES(D)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .shadow         (shadow),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic [LW-1:0] d0, input logic [LW-1:0] d1, input logic [LW-1:0] d2);
    req_data = {d2, d1, d0};
  endtask

  logic [NR-1:0] rr_grant [4];
  logic [31:0]   rr_wdata [4];

  initial begin
    rr_grant[0] = 3'b001; rr_wdata[0] = 32'h001;
    rr_grant[1] = 3'b010; rr_wdata[1] = 32'h002;
    rr_grant[2] = 3'b100; rr_wdata[2] = 32'h004;
    rr_grant[3] = 3'b001; rr_wdata[3] = 32'h001;

    reset = 1'b1;
    req_valid = '0;
    set_data('0, '0, '0);
    tick();
    tick();
    chk("rst_cs", pio_chipselect, 1'b0);
    chk("rst_wrn", pio_write_n, 1'b1);
    chk("rst_wdata", pio_writedata, 32'h0);
    chk("rst_addr", pio_address, 2'd0);
    chk("rst_shadow", shadow, 9'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", req_ready, 3'b000);
    reset = 1'b0;
    tick();

    // single request
    set_data(9'h0A5, 9'h000, 9'h000);
    req_valid = 3'b001;
    #1;
    chk("single_ready", req_ready, 3'b001);
    chk("single_busy_n", busy, 1'b0);
    tick();
    req_valid = 3'b000;
    #1;
    chk("single_cs", pio_chipselect, 1'b1);
    chk("single_wrn", pio_write_n, 1'b0);
    chk("single_wdata", pio_writedata, 32'h0000_00A5);
    chk("single_busy_w", busy, 1'b1);
    for (int i = 0; i < D; i++) begin
      tick();
      chk("single_dwell_busy", busy, 1'b1);
      chk("single_dwell_cs", pio_chipselect, 1'b0);
    end
    chk("single_shadow", shadow, 9'h0A5);
    tick();
    chk("single_busy_end", busy, 1'b0);

    // round robin after a fresh reset
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("rr_rst_shadow", shadow, 9'h0);
    set_data(9'h001, 9'h002, 9'h004);
    req_valid = 3'b111;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_grant", req_ready, rr_grant[k]);
      tick();
      chk("rr_cs", pio_chipselect, 1'b1);
      chk("rr_wdata", pio_writedata, rr_wdata[k]);
      chk("rr_ready_w", req_ready, 3'b000);
      for (int d = 0; d < D; d++) begin
        tick();
        chk("rr_ready_dwell", req_ready, 3'b000);
        chk("rr_cs_dwell", pio_chipselect, 1'b0);
      end
      tick();
    end
    req_valid = 3'b000;
    #1;

    // redundant suppression
    set_data(9'h1FF, 9'h000, 9'h000);
    req_valid = 3'b001;
    #1;
    chk("sup_ready0", req_ready, 3'b001);
    tick();
    req_valid = 3'b000;
    #1;
    chk("sup_wdata", pio_writedata, 32'h0000_01FF);
    repeat (D) tick();
    tick();
    chk("sup_shadow", shadow, 9'h1FF);
    set_data(9'h000, 9'h1FF, 9'h055);
    req_valid = 3'b010;
    #1;
    chk("sup_ready1", req_ready, 3'b010);
    tick();
    req_valid = 3'b100;
    #1;
    chk("sup_cs_none", pio_chipselect, 1'b0);
    chk("sup_busy_none", busy, 1'b0);
    chk("sup_ready2", req_ready, 3'b100);
    tick();
    req_valid = 3'b000;
    #1;
    chk("sup_cs2", pio_chipselect, 1'b1);
    chk("sup_wdata2", pio_writedata, 32'h0000_0055);

    // dwell enforcement
    tick();
    set_data(9'h123, 9'h000, 9'h000);
    req_valid = 3'b001;
    #1;
    chk("dw_ready_first", req_ready, 3'b000);
    for (int d = 1; d < D; d++) begin
      tick();
      chk("dw_ready_low", req_ready, 3'b000);
    end
    tick();
    chk("dw_ready_accept", req_ready, 3'b001);
    tick();
    req_valid = 3'b000;
    #1;
    chk("dw_wdata", pio_writedata, 32'h0000_0123);

    // reset during the WRITE cycle
    reset = 1'b1;
    #1;
    chk("mr_cs", pio_chipselect, 1'b0);
    chk("mr_wrn", pio_write_n, 1'b1);
    chk("mr_shadow", shadow, 9'h0);
    chk("mr_busy", busy, 1'b0);
    reset = 1'b0;
    set_data(9'h0AA, 9'h0BB, 9'h0CC);
    req_valid = 3'b111;
    #1;
    chk("mr_prio", req_ready, 3'b001);
    tick();
    req_valid = 3'b000;
    #1;
    chk("mr_wdata", pio_writedata, 32'h0000_00AA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
